ram_arbiter: RTL
================

# ram_arbiter

Two-port arbiter that shares the single byte-enabled data RAM between the processor data port (requester 0) and a secondary master such as a DMA or debug loader (requester 1). It sits between the masters and the RAM. Each cycle it grants at most one request, using round-robin priority, an optional bus lock and a starvation guard. It drives the RAM write strobe, byte enables, address and write data, and returns registered read data to the winner one cycle later.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (DW/8 byte enables)
- MAX_WAIT, 8, cycles a requester may wait before it gets forced priority (≥2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req  in  2  per-requester request, held until granted
- lock  in  2  owner keeps the grant on following cycles while req&lock
- we  in  2  per-requester write (1) / read (0)
- be  in  2×(DW/8)  per-requester byte enables
- addr  in  2×AW  per-requester address
- wdata  in  2×DW  per-requester write data
- gnt  out  2  one-hot or zero; request accepted this cycle (combinational)
- rvalid  out  2  read data valid for requester i (registered)
- rdata  out  DW  registered read data, shared by both requesters
- ram_we  out  1  RAM write strobe
- ram_be  out  DW/8  RAM byte enables
- ram_adr  out  AW  RAM address
- ram_wd  out  DW  RAM write data
- ram_rd  in  DW  RAM combinational read data

## Operation
- Transfer: a request is accepted on the cycle gnt[i]=1. The RAM performs the write on that clock edge, or presents read data combinationally in that cycle.
- Mux: ram_adr/ram_be/ram_wd take the granted requester's values. ram_we = gnt[i]&we[i]. With no grant: ram_we=0, ram_be=0, and address/data are don't-care (driven 0).
- Arbitration, in priority order:
  1. Starved: if wait_cnt[i]==MAX_WAIT-1 and req[i], grant i. This breaks any lock.
  2. Locked: if owner_vld, req[owner] and lock[owner], grant owner.
  3. Round-robin: grant the requester that is not last; if only one requests, grant it.
- State:
  - last (1 bit): updated to the granted index on every grant.
  - owner (1 bit) and owner_vld: set when the granted requester has lock=1; cleared when the owner is granted with lock=0, drops req, or is preempted.
- wait_cnt[i]: increments while req[i]&!gnt[i] and saturates at MAX_WAIT-1. Clears on gnt[i] or when !req[i].
- Read return: on a granted read, rdata<=ram_rd and rvalid[i]<=1 for one cycle; otherwise rvalid<=0 and rdata holds.
- Requester 0 (the single-cycle CPU) should sample rdata the cycle after gnt.

## Timing
- Grant latency: 0 cycles when uncontended. Read data latency: 1 cycle after gnt. Write completes at the edge ending the gnt cycle.
- Throughput: one access per cycle. Back-to-back grants to alternating requesters are allowed.
- Reset values: last=1 (so requester 0 wins the first contention), owner_vld=0, wait_cnt=0, rvalid=0, rdata=0.
- During reset, gnt is forced to 0 and ram_we=0.
- Reset mid-read: a pending rvalid is dropped; no rvalid is issued after reset.
- Simultaneous starvation of both requesters cannot occur while MAX_WAIT≥2. If it does, requester 0 wins.
- A locked owner that simultaneously drops lock is still granted that cycle, and ownership releases afterward.

## Structure
- Shared package mem_pkg: AW/DW defaults, the requester index type (logic [0:0]), and the constants REQ_CPU=0 and REQ_DMA=1.
- One sub-module, rr_pick2: combinational 2-way picker taking req, last, force and force_idx, returning a one-hot grant. Used by the arbiter's top level.
- The top module holds the FSM registers (last, owner, owner_vld), the wait counters, the RAM mux and the read-return register.

## Test plan
- Single requester: req=01, read of addr 0x40 with RAM word 0xDEADBEEF → gnt=01 in the same cycle; rvalid=01 and rdata=0xDEADBEEF the next cycle.
- Contention after reset: req=11 for 4 cycles, no lock → gnt sequence 01,10,01,10; ram_we follows the granted requester's we.
- Byte write: requester 1 writes be=0100, wdata=0x00AB0000 to 0x80 → ram_be=0100, ram_we=1. A subsequent read returns only byte 2 changed.
- Lock: requester 1 holds req&lock while requester 0 requests, MAX_WAIT=4 → gnt=10 for 3 cycles, then gnt=01 (forced), then back to 10.
- Reset mid-read: a read is granted and reset is asserted at the next edge → rvalid stays 0, rdata=0, wait_cnt=0, and the next contention grants requester 0.
- Idle: req=00 → gnt=00, ram_we=0, ram_be=0, rvalid stays 0, and rdata holds its last value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: default bus widths and requester indices.
package mem_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    typedef logic [0:0] req_idx_t;

    localparam req_idx_t REQ_CPU = 1'b0;
    localparam req_idx_t REQ_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: a forced index wins, otherwise round-robin against last.
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    input  logic       force_vld,
    input  req_idx_t   force_idx,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (force_vld) begin
            gnt = (force_idx == REQ_DMA) ? 2'b10 : 2'b01;
        end else if (req == 2'b11) begin
            gnt = (last == REQ_DMA) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one byte-enabled RAM between the CPU data port and a secondary master.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          lock,
    input  logic [1:0]          we,
    input  logic [2*(DW/8)-1:0] be,
    input  logic [2*AW-1:0]     addr,
    input  logic [2*DW-1:0]     wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DW-1:0]       rdata,
    output logic                ram_we,
    output logic [DW/8-1:0]     ram_be,
    output logic [AW-1:0]       ram_adr,
    output logic [DW-1:0]       ram_wd,
    input  logic [DW-1:0]       ram_rd
);

    localparam int unsigned BW  = DW / 8;
    localparam int unsigned WCW = $clog2(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT - 1);

    req_idx_t             last_q, last_d;
    req_idx_t             owner_q, owner_d;
    logic                 owner_vld_q, owner_vld_d;
    logic [1:0][WCW-1:0]  wait_q, wait_d;
    logic [1:0]           rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata_q, rdata_d;

    logic [1:0] starve;
    logic       lock_hit;
    logic       force_vld;
    req_idx_t   force_idx;
    logic [1:0] pick_gnt;
    logic       any_gnt;
    req_idx_t   gidx;

    // Starvation outranks the lock; requester 0 wins a (theoretical) double starve.
    always_comb begin
        starve[0] = req[0] && (wait_q[0] == WAIT_MAX);
        starve[1] = req[1] && (wait_q[1] == WAIT_MAX);
        lock_hit  = owner_vld_q && req[owner_q] && lock[owner_q];
        force_vld = starve[0] || starve[1] || lock_hit;
        force_idx = starve[0] ? REQ_CPU : (starve[1] ? REQ_DMA : owner_q);
    end

    rr_pick2 u_pick (
        .req       (req),
        .last      (last_q),
        .force_vld (force_vld),
        .force_idx (force_idx),
        .gnt       (pick_gnt)
    );

    // Grant and RAM mux; nothing reaches the RAM while reset is held.
    always_comb begin
        gnt     = reset ? 2'b00 : pick_gnt;
        any_gnt = |gnt;
        gidx    = gnt[1] ? REQ_DMA : REQ_CPU;
        ram_we  = any_gnt && we[gidx];
        ram_be  = '0;
        ram_adr = '0;
        ram_wd  = '0;
        if (gnt[1]) begin
            ram_be  = be[2*BW-1:BW];
            ram_adr = addr[2*AW-1:AW];
            ram_wd  = wdata[2*DW-1:DW];
        end else if (gnt[0]) begin
            ram_be  = be[BW-1:0];
            ram_adr = addr[AW-1:0];
            ram_wd  = wdata[DW-1:0];
        end
    end

    always_comb begin
        last_d      = last_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        rvalid_d    = 2'b00;
        rdata_d     = rdata_q;
        wait_d      = wait_q;
        if (any_gnt) begin
            last_d      = gidx;
            owner_d     = gidx;
            owner_vld_d = lock[gidx];
            rvalid_d    = gnt & ~we;
            if (!we[gidx]) begin
                rdata_d = ram_rd;
            end
        end else if (owner_vld_q && !req[owner_q]) begin
            owner_vld_d = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (!req[i] || gnt[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_MAX) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= REQ_DMA;
            owner_q     <= REQ_CPU;
            owner_vld_q <= 1'b0;
            wait_q      <= '0;
            rvalid_q    <= 2'b00;
            rdata_q     <= '0;
        end else begin
            last_q      <= last_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            wait_q      <= wait_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule
